// File: rtl/conv_row_sequencer.sv
// Single PE-row 1-D convolution sequencer: loads a filter and an ifmap row, MACs one tap per cycle,
// emits one psum per window and forwards the row downstream. Optional ZERO_SKIP_EN skips all-zero windows.
module conv_row_sequencer #(
    parameter int IFMAP_LENGTH  = 25,
    parameter int FILTER_TAPS   = 5,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int PSUM_WIDTH    = 13,
    parameter int CONVS_PER_ROW = 21,
    parameter int ROWS          = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  filter_valid,
    output logic                                  filter_ready,
    input  logic [FILTER_TAPS*WEIGHT_WIDTH-1:0]   filter_data,
    input  logic                                  ifmap_valid,
    output logic                                  ifmap_ready,
    input  logic [IFMAP_LENGTH-1:0]               ifmap_data,
    output logic                                  psum_valid,
    input  logic                                  psum_ready,
    output logic [PSUM_WIDTH-1:0]                 psum_data,
    output logic [$clog2(CONVS_PER_ROW)-1:0]      psum_conv_idx,
    output logic [$clog2(ROWS)-1:0]               psum_row_idx,
    output logic                                  fwd_valid,
    input  logic                                  fwd_ready,
    output logic [IFMAP_LENGTH-1:0]               fwd_data,
    output logic                                  busy
);
    localparam int CW = $clog2(CONVS_PER_ROW);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(FILTER_TAPS);
    localparam int PW = $clog2(IFMAP_LENGTH);

    typedef enum logic [2:0] {IDLE, WAIT_IFMAP, MAC, EMIT, FWD} state_t;

    state_t                                   state;
    logic                                     filterLoaded;
    logic [FILTER_TAPS-1:0][WEIGHT_WIDTH-1:0] weights;
    logic [IFMAP_LENGTH-1:0]                  ifmapRow;
    logic [CW-1:0]                            convIdx;
    logic [TW-1:0]                            tap;
    logic [RW-1:0]                            rowIdx;
    logic [PSUM_WIDTH-1:0]                    acc;
    logic                                     filterReady, ifmapReady, psumValid, fwdValid;

    logic                                     filterAcc, ifmapAcc;
    logic [PW-1:0]                            pos;
    logic [PSUM_WIDTH-1:0]                    term;

    assign filterAcc = filter_valid && filterReady;
    assign ifmapAcc  = ifmap_valid && ifmapReady;
    assign pos       = PW'(convIdx) + PW'(tap);
    assign term      = ifmapRow[pos] ? PSUM_WIDTH'(weights[tap]) : '0;

`ifdef ZERO_SKIP_EN
    logic windowZero;
    assign windowZero = (ifmapRow[convIdx +: FILTER_TAPS] == '0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            filterLoaded <= 1'b0;
            weights      <= '0;
            ifmapRow     <= '0;
            convIdx      <= '0;
            tap          <= '0;
            rowIdx       <= '0;
            acc          <= '0;
            filterReady  <= 1'b0;
            ifmapReady   <= 1'b0;
            psumValid    <= 1'b0;
            fwdValid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    filterReady <= 1'b1;
                    if (filterAcc) begin
                        weights      <= filter_data;
                        filterLoaded <= 1'b1;
                        ifmapReady   <= 1'b1;
                        state        <= WAIT_IFMAP;
                    end
                end
                WAIT_IFMAP: begin
                    // A filter accepted alongside the ifmap lands in the same edge, so it drives this row.
                    if (filterAcc) begin
                        weights      <= filter_data;
                        filterLoaded <= 1'b1;
                    end
                    if (ifmapAcc) begin
                        ifmapRow    <= ifmap_data;
                        convIdx     <= '0;
                        tap         <= '0;
                        acc         <= '0;
                        filterReady <= 1'b0;
                        ifmapReady  <= 1'b0;
                        state       <= MAC;
                    end else begin
                        filterReady <= 1'b1;
                        ifmapReady  <= filterLoaded || filterAcc;
                    end
                end
                MAC: begin
`ifdef ZERO_SKIP_EN
                    if (tap == '0 && windowZero) begin
                        acc       <= '0;
                        psumValid <= 1'b1;
                        state     <= EMIT;
                    end else
`endif
                    if (tap == TW'(FILTER_TAPS - 1)) begin
                        acc       <= acc + term;
                        psumValid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        acc <= acc + term;
                        tap <= tap + TW'(1);
                    end
                end
                EMIT: begin
                    if (psum_ready) begin
                        psumValid <= 1'b0;
                        if (convIdx == CW'(CONVS_PER_ROW - 1)) begin
                            fwdValid <= 1'b1;
                            state    <= FWD;
                        end else begin
                            convIdx <= convIdx + CW'(1);
                            tap     <= '0;
                            acc     <= '0;
                            state   <= MAC;
                        end
                    end
                end
                FWD: begin
                    if (fwd_ready) begin
                        fwdValid    <= 1'b0;
                        rowIdx      <= (rowIdx == RW'(ROWS - 1)) ? '0 : rowIdx + RW'(1);
                        filterReady <= 1'b1;
                        ifmapReady  <= filterLoaded;
                        state       <= WAIT_IFMAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign filter_ready  = filterReady;
    assign ifmap_ready   = ifmapReady;
    assign psum_valid    = psumValid;
    assign psum_data     = acc;
    assign psum_conv_idx = convIdx;
    assign psum_row_idx  = rowIdx;
    assign fwd_valid     = fwdValid;
    assign fwd_data      = ifmapRow;
    assign busy          = (state == MAC) || (state == EMIT) || (state == FWD);

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Bench for conv_row_sequencer: directed rows plus randomized rows/stalls against a window-sum model.
module tb_conv_row_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        filter_valid, filter_ready;
    logic [39:0] filter_data;
    logic        ifmap_valid, ifmap_ready;
    logic [24:0] ifmap_data;
    logic        psum_valid, psum_ready;
    logic [12:0] psum_data;
    logic [4:0]  psum_conv_idx;
    logic [2:0]  psum_row_idx;
    logic        fwd_valid, fwd_ready;
    logic [24:0] fwd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rowCount = 0;
    logic [39:0] curFilter = '0;

    conv_row_sequencer dut (
        .clk(clk), .reset(reset),
        .filter_valid(filter_valid), .filter_ready(filter_ready), .filter_data(filter_data),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready), .ifmap_data(ifmap_data),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
        .psum_conv_idx(psum_conv_idx), .psum_row_idx(psum_row_idx),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: window c sums weight t wherever spike c+t is set.
    function automatic int winSum(input logic [39:0] f, input logic [24:0] r, input int c);
        int s = 0;
        for (int t = 0; t < 5; t++)
            if (r[c + t]) s += int'(f[t*8 +: 8]);
        return s;
    endfunction

    task automatic loadFilter(input logic [39:0] f);
        int n = 0;
        filter_valid = 1'b1;
        filter_data  = f;
        while (!filter_ready && n < 50) begin tick(); n++; end
        check("filter_ready_wait", filter_ready, 1);
        tick();
        filter_valid = 1'b0;
        curFilter    = f;
    endtask

    task automatic runRow(input logic [39:0] f, input bit withFilter, input logic [24:0] row,
                          input int stallPct, input int stallConv,
                          output int firstLat, output int fwdLat);
        int  expSum [21];
        int  cyc, cIdx, stallCnt, n;
        bit  earlyFwd;
        if (withFilter) begin
            filter_valid = 1'b1;
            filter_data  = f;
            curFilter    = f;
        end
        for (int c = 0; c < 21; c++) expSum[c] = winSum(curFilter, row, c);
        ifmap_valid = 1'b1;
        ifmap_data  = row;
        n = 0;
        while (!ifmap_ready && n < 50) begin tick(); n++; end
        check("ifmap_ready_wait", ifmap_ready, 1);
        if (withFilter) check("filter_ready_with_ifmap", filter_ready, 1);
        tick();
        filter_valid = 1'b0;
        ifmap_valid  = 1'b0;
        cyc = 0; cIdx = 0; stallCnt = 0; firstLat = -1; fwdLat = -1; earlyFwd = 1'b0;
        while (cIdx < 21 && cyc < 3000) begin
            if (psum_valid && firstLat < 0) firstLat = cyc;
            earlyFwd |= fwd_valid;
            if (cIdx == stallConv && stallCnt < 10 && (psum_valid || stallCnt > 0)) begin
                psum_ready = 1'b0;
                stallCnt++;
                check("stall_psum_valid", psum_valid, 1);
                check("stall_psum_data", psum_data, expSum[cIdx]);
                check("stall_conv_idx", psum_conv_idx, cIdx);
                check("stall_busy", busy, 1);
            end else begin
                psum_ready = ($urandom_range(99) >= stallPct);
                if (psum_valid && psum_ready) begin
                    check("psum_data", psum_data, expSum[cIdx]);
                    check("psum_conv_idx", psum_conv_idx, cIdx);
                    check("psum_row_idx", psum_row_idx, rowCount % 5);
                    cIdx++;
                end
            end
            tick();
            cyc++;
        end
        psum_ready = 1'b0;
        check("psum_count", cIdx, 21);
        check("fwd_before_last_psum", earlyFwd, 0);
        while (!fwd_valid && cyc < 3000) begin tick(); cyc++; end
        fwdLat = cyc;
        check("fwd_valid", fwd_valid, 1);
        check("fwd_data", fwd_data, row);
        n = 0;
        while (n < 200) begin
            fwd_ready = ($urandom_range(99) >= stallPct);
            if (fwd_ready) break;
            tick(); n++;
        end
        tick();
        fwd_ready = 1'b0;
        check("fwd_done_valid", fwd_valid, 0);
        check("fwd_done_busy", busy, 0);
        check("ifmap_ready_next_row", ifmap_ready, 1);
        rowCount++;
    endtask

    initial begin
        int          firstLat, fwdLat, expFwdLat, n;
        logic [39:0] rf;
        logic [24:0] rr;
        logic [50:0] allOut;
`ifdef ZERO_SKIP_EN
        expFwdLat = 62;
`else
        expFwdLat = 126;
`endif
        reset = 1'b1;
        filter_valid = 1'b0; filter_data = '0;
        ifmap_valid = 1'b0;  ifmap_data = '0;
        psum_ready = 1'b0;   fwd_ready = 1'b0;

        // Reset state
        tick();
        allOut = {filter_ready, ifmap_ready, psum_valid, psum_data, psum_conv_idx,
                  psum_row_idx, fwd_valid, fwd_data, busy};
        check("reset_outputs", allOut, 0);
        reset = 1'b0;
        tick();
        check("idle_filter_ready", filter_ready, 1);
        check("idle_ifmap_ready", ifmap_ready, 0);
        check("idle_busy", busy, 0);

        // T1: ramp filter, five leading spikes
        loadFilter(40'h05_04_03_02_01);
        check("wait_ifmap_ready", ifmap_ready, 1);
        runRow(40'h0, 1'b0, 25'h000001F, 0, -1, firstLat, fwdLat);
        check("t1_first_latency", firstLat, 5);
        check("t1_fwd_latency", fwdLat, expFwdLat);

        // T2: all-max weights, all spikes, filter reloaded alongside the row
        runRow(40'hFF_FF_FF_FF_FF, 1'b1, 25'h1FFFFFF, 0, -1, firstLat, fwdLat);
        check("t2_first_latency", firstLat, 5);

        // T3: ten-cycle stall on conv 0
        runRow(40'h05_04_03_02_01, 1'b1, 25'h000001F, 0, 0, firstLat, fwdLat);

        // T4: consecutive randomized rows, row index wraps after 5
        for (int i = 0; i < 7; i++) begin
            rf = {$urandom, $urandom};
            rr = (i % 2 == 0) ? 25'($urandom) : 25'($urandom & $urandom & $urandom);
            runRow(rf, ($urandom_range(1) == 1), rr, 25, (i == 3) ? 7 : -1, firstLat, fwdLat);
        end

        // T5: reset mid-MAC (conv 3, tap 2)
        ifmap_valid = 1'b1;
        ifmap_data  = 25'h000001F;
        n = 0;
        while (!ifmap_ready && n < 50) begin tick(); n++; end
        tick();
        ifmap_valid = 1'b0;
        psum_ready  = 1'b1;
        repeat (20) tick();
        check("pre_reset_busy", busy, 1);
        check("pre_reset_conv_idx", psum_conv_idx, 3);
        reset = 1'b1;
        #1;
        allOut = {filter_ready, ifmap_ready, psum_valid, psum_data, psum_conv_idx,
                  psum_row_idx, fwd_valid, fwd_data, busy};
        check("midrun_reset_outputs", allOut, 0);
        tick();
        reset = 1'b0;
        psum_ready = 1'b0;
        rowCount = 0;
        ifmap_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_ifmap_ready", ifmap_ready, 0);
        end
        ifmap_valid = 1'b0;
        tick();
        loadFilter({$urandom, $urandom});
        runRow(40'h0, 1'b0, 25'($urandom), 20, -1, firstLat, fwdLat);
        runRow(40'h0, 1'b0, 25'($urandom & $urandom), 0, -1, firstLat, fwdLat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
